led_trail_pwm: RTL and testbench
================================

// Module: led_trail_pwm
// PURPOSE
//  Downstream of the LED walker: takes its one-hot WIDTH-bit LED vector and drives the physical pins.
//  Each pin is driven with PWM, so a lit LED leaves a fading trail (scanner effect).
//  A set input bit forces that LED to full brightness; brightness then decays in steps, paced by PWM frames.
// PARAMETERS
//  WIDTH         `DEFAULT_WIDTH        number of LEDs (input and output width)
//  PWM_BITS      `DEFAULT_PWM_BITS (4) brightness/counter width, legal 2..8; MAX = 2**PWM_BITS-1
//  DECAY_FRAMES  `DEFAULT_DECAY_FRAMES (2) PWM frames per decay step, >=1
//  DECAY_STEP    4                     brightness subtracted per decay step, 1..MAX
// PORTS
//  i_clk      in   1      system clock, all logic on posedge
//  i_reset_n  in   1      synchronous reset, active low
//  i_led      in   WIDTH  walker LED vector (any bit pattern legal, not only one-hot)
//  o_pwm      out  WIDTH  PWM drive to LED pins, registered
//  o_frame    out  1      1-cycle strobe, high in the cycle pwm_cnt==0
// BEHAVIOUR
//  Reset (i_reset_n==0 at posedge)
//   - pwm_cnt, frm_cnt, all b[i], all d[i] <= 0; o_pwm <= 0; o_frame <= 0.
//   - Takes effect the next cycle, including mid-frame; i_led is ignored during reset.
//  PWM counter
//   - pwm_cnt (PWM_BITS) counts 0..MAX-1, then wraps to 0. Frame = MAX cycles.
//   - wrap edge = the posedge where pwm_cnt==MAX-1.
//  Frame strobe
//   - o_frame <= (pwm_cnt==MAX-1); first pulse is MAX cycles after reset release.
//  Frame counter
//   - frm_cnt counts 0..DECAY_FRAMES-1, advancing on each wrap edge.
//   - decay edge = the wrap edge with frm_cnt==DECAY_FRAMES-1.
//  Brightness b[i] (PWM_BITS), updated every posedge, in priority order:
//   1. i_led[i]==1: b[i] <= MAX. Load beats a simultaneous decay.
//   2. Else, on a decay edge: b[i] <= (b[i] > DECAY_STEP) ? b[i]-DECAY_STEP : 0.
//      Saturating, never wraps below 0.
//   3. Else hold.
//  Duty shadow d[i]
//   - On each wrap edge, d[i] <= b[i] (registered value before this edge's update).
//   - Duty therefore changes only at frame boundaries; no mid-frame glitches.
//  Output
//   - o_pwm[i] <= (pwm_cnt < d[i]); unsigned compare.
//   - d==0: pin never high. d==MAX: pin high for all MAX cycles of the frame.
//  Latency
//   - i_led[i] high at cycle t: b[i]==MAX at t+1.
//   - d[i] loads at the first wrap edge after t+1.
//   - o_pwm[i] goes high 1 cycle after that wrap edge.
//  Behaviour at each frame
//   - A held-high i_led[i] keeps b[i] at MAX indefinitely.
//   - An input pulse shorter than a frame is never lost: b latches it.
// STRUCTURE
//  Shared header parameters.vh (existing) gains:
//   - `DEFAULT_PWM_BITS
//   - `DEFAULT_DECAY_FRAMES
//  Top level holds pwm_cnt, frm_cnt and o_frame, and generates the wrap/decay enables.
//  Sub-module led_trail_cell, generated WIDTH times:
//   - holds b, d and the o_pwm flop for one LED
//   - inputs: i_clk, i_reset_n, load, wrap, decay, pwm_cnt
// TESTING (WIDTH=8, PWM_BITS=4 -> MAX=15, DECAY_FRAMES=2, DECAY_STEP=4)
//  1. Reset held 5 cycles with i_led=8'hFF
//     -> o_pwm==0, o_frame==0 throughout.
//     -> after release with i_led=0: o_frame pulses every 15 cycles, first pulse 15 cycles after release; o_pwm stays 0.
//  2. i_led=8'h01 held
//     -> from the 2nd frame onward, o_pwm[0] high all 15 cycles of every frame; o_pwm[7:1]==0.
//  3. i_led[3] pulsed 1 cycle
//     -> o_pwm[3] high-cycles per frame: 15, 11, 7, 3, 0.
//     -> each value held 2 frames (the first held 1 or 2, depending on frm_cnt phase).
//     -> o_pwm[3] stays 0 afterwards.
//  4. i_led[2]=1 only in the decay-edge cycle, with b[2]==7
//     -> b[2]==15 next cycle; load wins over decay.
//  5. i_led walks 8'h01..8'h80 then back, one step per 15 cycles
//     -> while 8'h80 is lit: duty[6] >= duty[5] >= duty[4].
//     -> the lit LED's own duty is 15 from the following frame.
//  6. Reset asserted mid-frame (pwm_cnt==6, several b nonzero)
//     -> next cycle all b/d==0, o_pwm==0, pwm_cnt==0.
//     -> after release, behaviour identical to scenario 1.

Source files
------------

// File: rtl/led_trail_pwm_pkg.sv
// Shared defaults and helpers for the LED trail PWM driver.
package led_trail_pwm_pkg;

  localparam int DEFAULT_WIDTH        = 8;
  localparam int DEFAULT_PWM_BITS     = 4;
  localparam int DEFAULT_DECAY_FRAMES = 2;
  localparam int DEFAULT_DECAY_STEP   = 4;

  // Width of the frame counter; kept at least 1 bit so DECAY_FRAMES==1 still elaborates.
  function automatic int frm_width(input int frames);
    return (frames > 1) ? $clog2(frames) : 1;
  endfunction

endpackage

// File: rtl/led_trail_cell.sv
// One LED channel: brightness register, per-frame duty shadow and PWM output flop.
module led_trail_cell
  import led_trail_pwm_pkg::*;
#(
  parameter int PWM_BITS   = DEFAULT_PWM_BITS,
  parameter int DECAY_STEP = DEFAULT_DECAY_STEP
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_load,
  input  logic                i_wrap,
  input  logic                i_decay,
  input  logic [PWM_BITS-1:0] i_pwm_cnt,
  output logic                o_pwm
);

  localparam logic [PWM_BITS-1:0] MAX  = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(DECAY_STEP);

  logic [PWM_BITS-1:0] r_b;
  logic [PWM_BITS-1:0] r_d;
  logic                r_pwm;

  // Load to full brightness, else saturating decay; latch duty at frame wrap; compare for PWM.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_b   <= '0;
      r_d   <= '0;
      r_pwm <= 1'b0;
    end else begin
      if (i_load) begin
        r_b <= MAX;
      end else if (i_decay) begin
        r_b <= (r_b > STEP) ? (r_b - STEP) : '0;
      end
      // Duty takes the pre-update brightness so a frame never changes mid-way.
      if (i_wrap) begin
        r_d <= r_b;
      end
      r_pwm <= (i_pwm_cnt < r_d);
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/led_trail_pwm.sv
// LED trail driver: shared PWM/frame timing plus one brightness cell per LED.
module led_trail_pwm
  import led_trail_pwm_pkg::*;
#(
  parameter int WIDTH        = DEFAULT_WIDTH,
  parameter int PWM_BITS     = DEFAULT_PWM_BITS,
  parameter int DECAY_FRAMES = DEFAULT_DECAY_FRAMES,
  parameter int DECAY_STEP   = DEFAULT_DECAY_STEP
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [WIDTH-1:0] i_led,
  output logic [WIDTH-1:0] o_pwm,
  output logic             o_frame
);

  localparam int                  FRM_W    = frm_width(DECAY_FRAMES);
  localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'((2 ** PWM_BITS) - 2);
  localparam logic [FRM_W-1:0]    FRM_LAST = FRM_W'(DECAY_FRAMES - 1);

  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [FRM_W-1:0]    r_frm_cnt;
  logic                r_frame;
  logic                w_wrap;
  logic                w_decay;

  // A frame is MAX cycles: the counter runs 0..MAX-1, so the brightest duty fills every cycle.
  assign w_wrap  = (r_pwm_cnt == CNT_LAST);
  assign w_decay = w_wrap && (r_frm_cnt == FRM_LAST);

  // PWM counter, frame counter and registered frame strobe.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_pwm_cnt <= '0;
      r_frm_cnt <= '0;
      r_frame   <= 1'b0;
    end else begin
      r_pwm_cnt <= w_wrap ? '0 : (r_pwm_cnt + 1'b1);
      if (w_wrap) begin
        r_frm_cnt <= (r_frm_cnt == FRM_LAST) ? '0 : (r_frm_cnt + 1'b1);
      end
      r_frame <= w_wrap;
    end
  end

  assign o_frame = r_frame;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      led_trail_cell #(
        .PWM_BITS  (PWM_BITS),
        .DECAY_STEP(DECAY_STEP)
      ) u_cell (
        .i_clk    (i_clk),
        .i_reset_n(i_reset_n),
        .i_load   (i_led[gi]),
        .i_wrap   (w_wrap),
        .i_decay  (w_decay),
        .i_pwm_cnt(r_pwm_cnt),
        .o_pwm    (o_pwm[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_led_trail_pwm.sv
// Directed bench for led_trail_pwm (WIDTH=8, MAX=15, DECAY_FRAMES=2, DECAY_STEP=4).
// Edge E1 is the first posedge after reset release; window w holds the o_pwm samples
// taken after edges E(15w+1)..E(15w+15), i.e. one full PWM frame.
module tb_led_trail_pwm;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] led;
  logic [7:0] pwm;
  logic       frame;

  int errors = 0;
  int checks = 0;
  int edge_idx;
  int hi_cnt[0:15][0:7];

  led_trail_pwm #(
    .WIDTH       (8),
    .PWM_BITS    (4),
    .DECAY_FRAMES(2),
    .DECAY_STEP  (4)
  ) dut (
    .i_clk    (clk),
    .i_reset_n(reset_n),
    .i_led    (led),
    .o_pwm    (pwm),
    .o_frame  (frame)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  // One clock; sample 1ns after the edge and accumulate high cycles per frame window.
  task automatic tick();
    int w;
    @(posedge clk);
    #1;
    edge_idx++;
    w = (edge_idx - 1) / 15;
    if (w < 16) begin
      for (int b = 0; b < 8; b++) hi_cnt[w][b] += int'(pwm[b]);
    end
  endtask

  // Hold reset n cycles checking outputs stay 0, then release with i_led=0.
  task automatic hold_reset(input int n, input logic [7:0] led_val);
    reset_n = 1'b0;
    led     = led_val;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (pwm !== 8'h00 || frame !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: o_pwm=%h o_frame=%b, required 00/0", i, pwm, frame);
      end
    end
    reset_n  = 1'b1;
    led      = 8'h00;
    edge_idx = 0;
    for (int w = 0; w < 16; w++)
      for (int b = 0; b < 8; b++) hi_cnt[w][b] = 0;
  endtask

  // After a release with no LEDs lit: strobe every 15th edge, pins dark.
  task automatic check_idle(input int nframes, input string tag);
    logic exp_frame;
    for (int k = 0; k < nframes * 15; k++) begin
      tick();
      exp_frame = ((edge_idx % 15) == 0);
      checks++;
      if (frame !== exp_frame || pwm !== 8'h00) begin
        errors++;
        $display("FAIL %s edge %0d: o_frame=%b o_pwm=%h, required %b/00",
                 tag, edge_idx, frame, pwm, exp_frame);
      end
    end
    $display("%s: %0d idle frames checked", tag, nframes);
  endtask

  task automatic test_reset();
    hold_reset(5, 8'hFF);
    check_idle(3, "reset_release");
  endtask

  task automatic test_held();
    hold_reset(2, 8'h00);
    led = 8'h01;
    repeat (75) tick();
    led = 8'h00;
    for (int w = 0; w < 5; w++) begin
      checks++;
      if (hi_cnt[w][0] !== ((w == 0) ? 0 : 15)) begin
        errors++;
        $display("FAIL held_bit0 frame %0d: high=%0d, required %0d", w, hi_cnt[w][0], (w == 0) ? 0 : 15);
      end
      for (int b = 1; b < 8; b++) begin
        checks++;
        if (hi_cnt[w][b] !== 0) begin
          errors++;
          $display("FAIL held_other frame %0d bit %0d: high=%0d, required 0", w, b, hi_cnt[w][b]);
        end
      end
    end
    $display("held: bit0 frame highs %0d %0d %0d", hi_cnt[0][0], hi_cnt[1][0], hi_cnt[2][0]);
  endtask

  task automatic test_pulse();
    int exp3[0:10] = '{0, 15, 15, 11, 11, 7, 7, 3, 3, 0, 0};
    hold_reset(2, 8'h00);
    led = 8'h08;
    tick();
    led = 8'h00;
    while (edge_idx < 165) tick();
    for (int w = 0; w < 11; w++) begin
      checks++;
      if (hi_cnt[w][3] !== exp3[w]) begin
        errors++;
        $display("FAIL pulse_decay frame %0d: high=%0d, required %0d", w, hi_cnt[w][3], exp3[w]);
      end
      checks++;
      if (hi_cnt[w][0] + hi_cnt[w][7] + hi_cnt[w][2] + hi_cnt[w][4] !== 0) begin
        errors++;
        $display("FAIL pulse_other frame %0d: high=%0d, required 0", w,
                 hi_cnt[w][0] + hi_cnt[w][7] + hi_cnt[w][2] + hi_cnt[w][4]);
      end
    end
    $display("pulse: bit3 decay sequence checked over 11 frames");
  endtask

  // Reload lands on decay edge E90 while b[2]==7: load must win.
  task automatic test_load_beats_decay();
    int exp2[0:9] = '{0, 15, 15, 11, 11, 7, 7, 15, 15, 11};
    hold_reset(2, 8'h00);
    led = 8'h04;
    tick();
    led = 8'h00;
    while (edge_idx < 89) tick();
    led = 8'h04;
    tick();
    led = 8'h00;
    while (edge_idx < 150) tick();
    for (int w = 0; w < 10; w++) begin
      checks++;
      if (hi_cnt[w][2] !== exp2[w]) begin
        errors++;
        $display("FAIL load_vs_decay frame %0d: high=%0d, required %0d", w, hi_cnt[w][2], exp2[w]);
      end
    end
    $display("load_vs_decay: bit2 frame 7 high=%0d", hi_cnt[7][2]);
  endtask

  task automatic test_walk();
    int exp7[0:7] = '{3, 7, 7, 11, 11, 15, 15, 0};
    hold_reset(2, 8'h00);
    for (int s = 0; s < 15; s++) begin
      led = (s < 8) ? (8'h01 << s) : (8'h01 << (14 - s));
      repeat (15) tick();
    end
    led = 8'h00;
    for (int b = 0; b < 8; b++) begin
      checks++;
      if (hi_cnt[7][b] !== exp7[b]) begin
        errors++;
        $display("FAIL walk_frame7 bit %0d: high=%0d, required %0d", b, hi_cnt[7][b], exp7[b]);
      end
    end
    checks++;
    if (!(hi_cnt[7][6] >= hi_cnt[7][5] && hi_cnt[7][5] >= hi_cnt[7][4])) begin
      errors++;
      $display("FAIL walk_order: duty6=%0d duty5=%0d duty4=%0d, required non-increasing",
               hi_cnt[7][6], hi_cnt[7][5], hi_cnt[7][4]);
    end
    checks++;
    if (hi_cnt[8][7] !== 15) begin
      errors++;
      $display("FAIL walk_lit_next bit7 frame 8: high=%0d, required 15", hi_cnt[8][7]);
    end
    $display("walk: frame7 duties 4/5/6/7 = %0d %0d %0d %0d",
             hi_cnt[7][4], hi_cnt[7][5], hi_cnt[7][6], hi_cnt[7][7]);
  endtask

  task automatic test_mid_reset();
    hold_reset(2, 8'h00);
    led = 8'hF0;
    tick();
    led = 8'h00;
    while (edge_idx < 21) tick();
    checks++;
    if (pwm !== 8'hF0 || dut.r_pwm_cnt !== 4'd6) begin
      errors++;
      $display("FAIL mid_reset_pre: o_pwm=%h pwm_cnt=%0d, required f0/6", pwm, dut.r_pwm_cnt);
    end
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (pwm !== 8'h00 || frame !== 1'b0 || dut.r_pwm_cnt !== 4'd0) begin
      errors++;
      $display("FAIL mid_reset_next: o_pwm=%h o_frame=%b pwm_cnt=%0d, required 00/0/0",
               pwm, frame, dut.r_pwm_cnt);
    end
    hold_reset(1, 8'hFF);
    check_idle(3, "mid_reset_release");
  endtask

  initial begin
    reset_n = 1'b0;
    led     = 8'h00;
    edge_idx = 0;
    test_reset();
    test_held();
    test_pulse();
    test_load_beats_decay();
    test_walk();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
